// File: rtl/tcdm_tx_rd_engine.sv
// TCDM read-side TX engine: issues reads for command beats, buffers returned data in
// order and hands it to the TX data channel; a credit counter bounds outstanding reads.

module tcdm_tx_rd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scan_en,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy is tracked by the owner, so the pointers only ever advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop)  rptr <= nxt(rptr);
        end
    end

    // In scan mode the write port stays enabled and recirculates the stored word.
    always_ff @(posedge clk) begin
        if (push || scan_en) mem[wptr] <= push ? din : mem[wptr];
    end

    assign dout = mem[rptr];
endmodule

module tcdm_tx_rd_engine #(
    parameter int TRANS_SID_WIDTH = 2,
    parameter int TCDM_ADD_WIDTH  = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scan_ckgt_enable_i,
    input  logic                       beat_eop_i,
    input  logic [TRANS_SID_WIDTH-1:0] beat_sid_i,
    input  logic [TCDM_ADD_WIDTH-1:0]  beat_add_i,
    input  logic [DATA_WIDTH/8-1:0]    beat_be_i,
    input  logic                       beat_we_n_i,
    input  logic                       beat_req_i,
    output logic                       beat_gnt_o,
    output logic                       tcdm_req_o,
    output logic [31:0]                tcdm_add_o,
    output logic                       tcdm_we_n_o,
    output logic [DATA_WIDTH-1:0]      tcdm_wdata_o,
    output logic [DATA_WIDTH/8-1:0]    tcdm_be_o,
    output logic [TRANS_SID_WIDTH-1:0] tcdm_sid_o,
    input  logic                       tcdm_gnt_i,
    input  logic [DATA_WIDTH-1:0]      tcdm_r_rdata_i,
    input  logic                       tcdm_r_valid_i,
    output logic [DATA_WIDTH-1:0]      tx_data_dat_o,
    output logic                       tx_data_req_o,
    input  logic                       tx_data_gnt_i,
    output logic                       synch_req_o,
    output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
    output logic                       busy_o,
    output logic                       err_rvalid_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]              cnt, dcnt, inflight;
    logic                       issue, pop, rd_push;
    logic [TRANS_SID_WIDTH:0]   cmd_head;
    logic [DATA_WIDTH-1:0]      dat_head;

    assign tcdm_req_o   = beat_req_i & beat_we_n_i & (cnt < CW'(DEPTH));
    assign issue        = tcdm_req_o & tcdm_gnt_i;
    assign beat_gnt_o   = issue;
    assign tcdm_add_o   = 32'(beat_add_i);
    assign tcdm_we_n_o  = beat_we_n_i;
    assign tcdm_wdata_o = '0;
    assign tcdm_be_o    = beat_be_i;
    assign tcdm_sid_o   = beat_sid_i;

    // cnt covers issued-but-unreturned plus buffered beats; dcnt only the buffered ones.
    assign inflight = cnt - dcnt;
    assign rd_push  = tcdm_r_valid_i & (inflight != '0);

    assign tx_data_req_o = (dcnt != '0);
    assign pop           = tx_data_req_o & tx_data_gnt_i;
    assign tx_data_dat_o = tx_data_req_o ? dat_head : '0;
    assign synch_sid_o   = tx_data_req_o ? cmd_head[TRANS_SID_WIDTH:1] : '0;
    assign synch_req_o   = pop & cmd_head[0];

    tcdm_tx_rd_fifo #(.W(TRANS_SID_WIDTH + 1), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk(clk_i), .rst_n(rst_ni), .scan_en(scan_ckgt_enable_i),
        .push(issue), .din({beat_sid_i, beat_eop_i}), .pop(pop), .dout(cmd_head)
    );

    tcdm_tx_rd_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_dat_fifo (
        .clk(clk_i), .rst_n(rst_ni), .scan_en(scan_ckgt_enable_i),
        .push(rd_push), .din(tcdm_r_rdata_i), .pop(pop), .dout(dat_head)
    );

    logic [CW-1:0] cnt_next, dcnt_next;

    always_comb begin
        cnt_next = cnt;
        case ({issue, pop})
            2'b10:   cnt_next = cnt + 1'b1;
            2'b01:   cnt_next = cnt - 1'b1;
            default: cnt_next = cnt;
        endcase
        dcnt_next = dcnt;
        case ({rd_push, pop})
            2'b10:   dcnt_next = dcnt + 1'b1;
            2'b01:   dcnt_next = dcnt - 1'b1;
            default: dcnt_next = dcnt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt          <= '0;
            dcnt         <= '0;
            busy_o       <= 1'b0;
            err_rvalid_o <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            dcnt         <= dcnt_next;
            busy_o       <= (cnt_next != '0);
            err_rvalid_o <= tcdm_r_valid_i & (inflight == '0);
        end
    end
endmodule

// File: tb/tb_tcdm_tx_rd_engine.sv
// Bench for tcdm_tx_rd_engine: idle-state vector table, directed corner sequences,
// a 64-bit instance, and a randomized run against a queue-based reference model.
module tb_tcdm_tx_rd_engine;
    localparam int SW = 2, AW = 12, DEPTH = 4;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic            scan = 0;
    logic            beat_eop = 0, beat_we_n = 1, beat_req = 0, tcdm_gnt = 0, tx_gnt = 0;
    logic [SW-1:0]   beat_sid = 0;
    logic [AW-1:0]   beat_add = 0;
    logic [3:0]      beat_be = 0;
    logic            m_rv = 0, a_rv = 0, auto_rsp = 0, r_valid;
    logic [31:0]     m_rdata = 0, a_rdata = 0, r_rdata;
    int              a_idx = 0;

    logic            beat_gnt, tcdm_req, tcdm_we_n, tx_req, synch_req, busy, err;
    logic [31:0]     tcdm_add, tcdm_wdata, tx_dat;
    logic [3:0]      tcdm_be;
    logic [SW-1:0]   tcdm_sid, synch_sid;

    assign r_valid = auto_rsp ? a_rv : m_rv;
    assign r_rdata = auto_rsp ? a_rdata : m_rdata;

    tcdm_tx_rd_engine #(.TRANS_SID_WIDTH(SW), .TCDM_ADD_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .scan_ckgt_enable_i(scan),
        .beat_eop_i(beat_eop), .beat_sid_i(beat_sid), .beat_add_i(beat_add), .beat_be_i(beat_be),
        .beat_we_n_i(beat_we_n), .beat_req_i(beat_req), .beat_gnt_o(beat_gnt),
        .tcdm_req_o(tcdm_req), .tcdm_add_o(tcdm_add), .tcdm_we_n_o(tcdm_we_n), .tcdm_wdata_o(tcdm_wdata),
        .tcdm_be_o(tcdm_be), .tcdm_sid_o(tcdm_sid), .tcdm_gnt_i(tcdm_gnt),
        .tcdm_r_rdata_i(r_rdata), .tcdm_r_valid_i(r_valid),
        .tx_data_dat_o(tx_dat), .tx_data_req_o(tx_req), .tx_data_gnt_i(tx_gnt),
        .synch_req_o(synch_req), .synch_sid_o(synch_sid), .busy_o(busy), .err_rvalid_o(err)
    );

    // 64-bit instance, idle unless w_req is raised
    logic            w_req = 0, w_gnt = 0, w_rv = 0, w_txgnt = 0;
    logic [7:0]      w_be_in = 0;
    logic [63:0]     w_rdata = 0;
    logic            w_bgnt, w_treq, w_we_n, w_txreq, w_synch, w_busy, w_err;
    logic [31:0]     w_add;
    logic [63:0]     w_wdata, w_dat;
    logic [7:0]      w_be;
    logic [SW-1:0]   w_sid, w_ssid;

    tcdm_tx_rd_engine #(.TRANS_SID_WIDTH(SW), .TCDM_ADD_WIDTH(AW), .DATA_WIDTH(64), .DEPTH(DEPTH)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .scan_ckgt_enable_i(scan),
        .beat_eop_i(beat_eop), .beat_sid_i(beat_sid), .beat_add_i(beat_add), .beat_be_i(w_be_in),
        .beat_we_n_i(beat_we_n), .beat_req_i(w_req), .beat_gnt_o(w_bgnt),
        .tcdm_req_o(w_treq), .tcdm_add_o(w_add), .tcdm_we_n_o(w_we_n), .tcdm_wdata_o(w_wdata),
        .tcdm_be_o(w_be), .tcdm_sid_o(w_sid), .tcdm_gnt_i(w_gnt),
        .tcdm_r_rdata_i(w_rdata), .tcdm_r_valid_i(w_rv),
        .tx_data_dat_o(w_dat), .tx_data_req_o(w_txreq), .tx_data_gnt_i(w_txgnt),
        .synch_req_o(w_synch), .synch_sid_o(w_ssid), .busy_o(w_busy), .err_rvalid_o(w_err)
    );

    // Latency-1 TCDM responder used by the backpressure sequence
    always @(posedge clk) begin
        a_rv <= tcdm_req & tcdm_gnt;
        if (tcdm_req & tcdm_gnt) begin
            a_rdata <= 32'hA000_0000 + 32'(a_idx);
            a_idx   <= a_idx + 1;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic req, we_n, gnt;
        logic [AW-1:0] add;
        logic [3:0] be;
        logic [SW-1:0] sid;
        logic exp_req, exp_bgnt;
    } vec_t;
    vec_t tbl[6];

    typedef struct {
        logic [SW-1:0] sid;
        logic eop;
        logic [31:0] data;
        int rdy;
    } ent_t;
    ent_t q[$];

    initial begin
        int base, grants, k, nret;
        logic exp_err, exp_req, ex_tx, rv_ok, spur, iss, pp;

        tbl[0] = '{1, 1, 1, 12'h010, 4'hF, 2'd2, 1, 1};
        tbl[1] = '{1, 1, 0, 12'h020, 4'h3, 2'd1, 1, 0};
        tbl[2] = '{1, 0, 1, 12'h030, 4'h1, 2'd0, 0, 0};
        tbl[3] = '{0, 1, 1, 12'h040, 4'h8, 2'd3, 0, 0};
        tbl[4] = '{0, 0, 0, 12'h000, 4'h0, 2'd0, 0, 0};
        tbl[5] = '{1, 1, 1, 12'hFFF, 4'h5, 2'd1, 1, 1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst tcdm_req", tcdm_req, 0);
        chk("rst beat_gnt", beat_gnt, 0);
        chk("rst tx_req", tx_req, 0);
        chk("rst synch_req", synch_req, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        chk("rst synch_sid", synch_sid, 0);
        chk("rst tx_dat", tx_dat, 0);
        rst_n = 1;

        // idle combinational vectors; beat_req is dropped before each rising edge
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            beat_req = tbl[i].req; beat_we_n = tbl[i].we_n; tcdm_gnt = tbl[i].gnt;
            beat_add = tbl[i].add; beat_be = tbl[i].be; beat_sid = tbl[i].sid;
            #1;
            chk("vec tcdm_req", tcdm_req, tbl[i].exp_req);
            chk("vec beat_gnt", beat_gnt, tbl[i].exp_bgnt);
            chk("vec tcdm_add", tcdm_add, {20'h0, tbl[i].add});
            chk("vec tcdm_be", tcdm_be, tbl[i].be);
            chk("vec tcdm_sid", tcdm_sid, tbl[i].sid);
            chk("vec tcdm_we_n", tcdm_we_n, tbl[i].we_n);
            chk("vec tcdm_wdata", tcdm_wdata, 0);
            beat_req = 0;
        end
        beat_we_n = 1;

        // single-beat read
        step();
        beat_req = 1; beat_add = 12'h010; beat_eop = 1; beat_sid = 2; tcdm_gnt = 1; tx_gnt = 1;
        @(negedge clk);
        chk("single t0 beat_gnt", beat_gnt, 1);
        step();
        beat_req = 0; m_rv = 1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("single t1 tx_req", tx_req, 0);
        chk("single t1 busy", busy, 1);
        step();
        m_rv = 0;
        @(negedge clk);
        chk("single t2 tx_req", tx_req, 1);
        chk("single t2 dat", tx_dat, 32'hDEADBEEF);
        chk("single t2 synch_req", synch_req, 1);
        chk("single t2 synch_sid", synch_sid, 2);
        step();
        @(negedge clk);
        chk("single t3 busy", busy, 0);
        chk("single t3 tx_req", tx_req, 0);

        // backpressure, then full with simultaneous pop, then sustained flow and drain
        step();
        auto_rsp = 1; base = a_idx; grants = 0; beat_eop = 0; beat_sid = 1;
        beat_req = 1; tx_gnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            grants += int'(beat_gnt);
            step();
        end
        @(negedge clk);
        chk("bp grants", grants, 4);
        chk("bp tcdm_req low", tcdm_req, 0);
        chk("bp busy", busy, 1);
        step();
        tx_gnt = 1;
        @(negedge clk);
        chk("full+pop no issue", tcdm_req, 0);
        chk("full+pop tx_req", tx_req, 1);
        chk("full+pop dat", tx_dat, 32'hA000_0000 + 32'(base));
        k = 1;
        step();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("sustained beat_gnt", beat_gnt, 1);
            grants += int'(beat_gnt);
            if (tx_req) begin
                chk("sustained dat", tx_dat, 32'hA000_0000 + 32'(base + k));
                k++;
            end
            step();
        end
        beat_req = 0;
        for (int c = 0; c < 20 && k < grants; c++) begin
            @(negedge clk);
            if (tx_req) begin
                chk("drain dat", tx_dat, 32'hA000_0000 + 32'(base + k));
                k++;
            end
            step();
        end
        chk("drain count", k, grants);
        step();
        @(negedge clk);
        chk("drain busy", busy, 0);
        step();
        auto_rsp = 0;

        // write beats are never requested
        beat_req = 1; beat_we_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("write tcdm_req", tcdm_req, 0);
            chk("write beat_gnt", beat_gnt, 0);
            step();
        end
        @(negedge clk);
        chk("write busy", busy, 0);
        step();
        beat_req = 0; beat_we_n = 1;

        // unexpected rvalid on an idle engine
        m_rv = 1; m_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("unexp err early", err, 0);
        step();
        m_rv = 0;
        @(negedge clk);
        chk("unexp err", err, 1);
        chk("unexp tx_req", tx_req, 0);
        step();
        @(negedge clk);
        chk("unexp err clears", err, 0);
        chk("unexp busy", busy, 0);

        // reset with three reads in flight
        step();
        tx_gnt = 0; beat_req = 1;
        repeat (3) step();
        beat_req = 0; rst_n = 0;
        @(negedge clk);
        chk("midrst tx_req", tx_req, 0);
        chk("midrst busy", busy, 0);
        chk("midrst err", err, 0);
        chk("midrst synch_req", synch_req, 0);
        chk("midrst dat", tx_dat, 0);
        step();
        rst_n = 1; tx_gnt = 1;
        m_rv = 1; m_rdata = 32'hBAD0_0000;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("late rvalid err", err, 1);
            chk("late rvalid tx_req", tx_req, 0);
        end
        step();
        m_rv = 0;
        beat_req = 1; beat_sid = 1; beat_eop = 1;
        @(negedge clk);
        chk("postrst beat_gnt", beat_gnt, 1);
        step();
        beat_req = 0; m_rv = 1; m_rdata = 32'h55AA_33CC;
        step();
        m_rv = 0;
        @(negedge clk);
        chk("postrst tx_req", tx_req, 1);
        chk("postrst dat", tx_dat, 32'h55AA_33CC);
        chk("postrst synch", synch_req, 1);
        chk("postrst synch_sid", synch_sid, 1);
        step();

        // 64-bit instance
        w_req = 1; w_be_in = 8'h0F; w_gnt = 1; w_txgnt = 1; beat_sid = 3; beat_eop = 1;
        @(negedge clk);
        chk("w64 be", w_be, 8'h0F);
        chk("w64 beat_gnt", w_bgnt, 1);
        step();
        w_req = 0; w_rv = 1; w_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        w_rv = 0;
        @(negedge clk);
        chk("w64 tx_req", w_txreq, 1);
        chk("w64 dat", w_dat, 64'h0123_4567_89AB_CDEF);
        chk("w64 synch_sid", w_ssid, 3);
        step();

        // randomized run against a queue model: q holds issued beats in order,
        // the first nret of them have data buffered
        nret = 0; exp_err = 0;
        for (int c = 0; c < 400; c++) begin
            beat_req  = ($urandom_range(0, 3) != 0);
            beat_we_n = ($urandom_range(0, 7) != 0);
            beat_eop  = 1'($urandom);
            beat_sid  = SW'($urandom);
            beat_add  = AW'($urandom);
            beat_be   = 4'($urandom);
            tcdm_gnt  = ($urandom_range(0, 3) != 0);
            tx_gnt    = ($urandom_range(0, 2) != 0);
            rv_ok = (q.size() > nret) && (q[nret].rdy <= c) && ($urandom_range(0, 3) != 0);
            spur  = (q.size() == nret) && ($urandom_range(0, 19) == 0);
            m_rv    = rv_ok | spur;
            m_rdata = rv_ok ? q[nret].data : $urandom;
            exp_req = beat_req & beat_we_n & (q.size() < DEPTH);
            ex_tx   = (nret > 0);
            @(negedge clk);
            chk("rnd tcdm_req", tcdm_req, exp_req);
            chk("rnd beat_gnt", beat_gnt, exp_req & tcdm_gnt);
            chk("rnd tx_req", tx_req, ex_tx);
            chk("rnd dat", tx_dat, ex_tx ? q[0].data : 32'h0);
            chk("rnd synch_req", synch_req, ex_tx & tx_gnt & q[0].eop);
            chk("rnd synch_sid", synch_sid, ex_tx ? q[0].sid : 2'd0);
            chk("rnd busy", busy, q.size() != 0);
            chk("rnd err", err, exp_err);
            iss = exp_req & tcdm_gnt;
            pp  = ex_tx & tx_gnt;
            step();
            if (rv_ok) nret++;
            if (pp) begin
                void'(q.pop_front());
                nret--;
            end
            if (iss) q.push_back('{beat_sid, beat_eop, $urandom, c + 1});
            exp_err = spur;
        end
        m_rv = 0; beat_req = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
